// File: rtl/scarv_cop_idecode_queue_pkg.sv
// rtl/scarv_cop_idecode_queue_pkg.sv - shared COP constants: mccr bits, class/subclass indices, pack widths
package scarv_cop_idecode_queue_pkg;

   localparam int MCCR_R   = 0;
   localparam int MCCR_MP  = 1;
   localparam int MCCR_SG  = 2;
   localparam int MCCR_P32 = 3;
   localparam int MCCR_P16 = 4;
   localparam int MCCR_P8  = 5;
   localparam int MCCR_P4  = 6;
   localparam int MCCR_P2  = 7;

   localparam int ICLASS_W             = 9;
   localparam int ICLASS_PACKED_ARITH  = 0;
   localparam int ICLASS_TWIDDLE       = 1;
   localparam int ICLASS_LOADSTORE     = 2;
   localparam int ICLASS_RANDOM        = 3;
   localparam int ICLASS_MOVE          = 4;
   localparam int ICLASS_MP            = 5;
   localparam int ICLASS_BITWISE       = 6;
   localparam int ICLASS_PERMUTE       = 7;
   localparam int ICLASS_MISC          = 8;

   localparam int SCLASS_W             = 16;
   localparam int SCLASS_SCATTER_B     = 4;
   localparam int SCLASS_SCATTER_H     = 5;
   localparam int SCLASS_GATHER_B      = 6;
   localparam int SCLASS_GATHER_H      = 7;

   localparam logic [6:0] COP_OPCODE   = 7'b0001011;

   typedef enum logic [2:0] {
      PW_32 = 3'd0,
      PW_16 = 3'd1,
      PW_8  = 3'd2,
      PW_4  = 3'd3,
      PW_2  = 3'd4
   } pack_width_t;

   // Reserved width codes are not a feature issue; the decoder flags them as illegal.
   function automatic logic pw_enabled(input pack_width_t pw, input logic [7:0] m);
      case (pw)
         PW_32:   return m[MCCR_P32];
         PW_16:   return m[MCCR_P16];
         PW_8:    return m[MCCR_P8];
         PW_4:    return m[MCCR_P4];
         PW_2:    return m[MCCR_P2];
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/scarv_cop_idec_core.sv
// rtl/scarv_cop_idec_core.sv - combinational COP word decode: class, subclass, pack width, base illegal
module scarv_cop_idec_core
   import scarv_cop_idecode_queue_pkg::*;
(
   input  logic [31:0]          encoded,
   output logic [ICLASS_W-1:0]  iclass,
   output logic [SCLASS_W-1:0]  sclass,
   output logic [2:0]           pack_width,
   output logic                 illegal
);

   logic [3:0] class_field;
   logic [3:0] sub_field;
   logic       unused_bits;

   assign class_field = encoded[31:28];
   assign sub_field   = encoded[27:24];
   assign pack_width  = encoded[23:21];
   assign unused_bits = ^encoded[20:7];

   always_comb begin
      iclass = '0;
      sclass = '0;
      if (class_field < 4'(ICLASS_W)) begin
         iclass[class_field] = 1'b1;
      end
      sclass[sub_field] = 1'b1;
      illegal = (encoded[6:0] != COP_OPCODE)
             || (class_field >= 4'(ICLASS_W))
             || ((class_field == 4'(ICLASS_PACKED_ARITH)) && (pack_width > PW_2));
   end

endmodule

// File: rtl/scarv_cop_idecode_queue.sv
// rtl/scarv_cop_idecode_queue.sv - COP instruction decode FIFO; SCARV_COP_IDQ_BYPASS_EN enables empty-queue bypass
module scarv_cop_idecode_queue
   import scarv_cop_idecode_queue_pkg::*;
#(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] MCCR_MASK = 8'hFF
) (
   input  logic                   g_clk,
   input  logic                   g_resetn,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_encoded,
   input  logic [7:0]             mccr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_encoded,
   output logic [8:0]             out_class,
   output logic [15:0]            out_subclass,
   output logic                   out_exception,
   output logic                   out_exc_feature,
   output logic [$clog2(DEPTH):0] count
);

   localparam int              PW       = $clog2(DEPTH);
   localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

   logic [PW:0]   count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   word_q [DEPTH];
   logic [7:0]    mccr_q [DEPTH];

   logic          bypass, do_enq, do_deq;
   logic [7:0]    mccr_masked, head_mccr;
   logic [31:0]   head_word;
   logic [8:0]    head_class;
   logic [15:0]   head_sub;
   logic [2:0]    head_pw;
   logic          head_illegal, head_feature;

   assign mccr_masked = mccr & MCCR_MASK;

`ifdef SCARV_COP_IDQ_BYPASS_EN
   assign bypass = (count_q == '0) && in_valid && !flush && g_resetn;
`else
   assign bypass = 1'b0;
`endif

   assign in_ready  = (count_q != CNT_FULL);
   assign out_valid = (count_q != '0) || bypass;
   assign count     = count_q;

   // A bypassed word that is consumed in the same cycle never enters storage.
   assign do_enq = in_valid && in_ready && !flush && !(bypass && out_ready);
   assign do_deq = (count_q != '0) && out_ready && !flush;

   assign head_word = bypass ? in_encoded  : word_q[rd_ptr_q];
   assign head_mccr = bypass ? mccr_masked : mccr_q[rd_ptr_q];

   scarv_cop_idec_core u_idec_core (
      .encoded    (head_word),
      .iclass     (head_class),
      .sclass     (head_sub),
      .pack_width (head_pw),
      .illegal    (head_illegal)
   );

   // Feature gating uses the mccr captured with the entry, not the live value.
   assign head_feature =
        (head_class[ICLASS_RANDOM]    && !head_mccr[MCCR_R])
     || (head_class[ICLASS_MP]        && !head_mccr[MCCR_MP])
     || (head_class[ICLASS_LOADSTORE] && (|head_sub[SCLASS_GATHER_H:SCLASS_SCATTER_B])
                                      && !head_mccr[MCCR_SG])
     || (head_class[ICLASS_PACKED_ARITH] && !pw_enabled(pack_width_t'(head_pw), head_mccr));

   always_comb begin
      out_encoded     = '0;
      out_class       = '0;
      out_subclass    = '0;
      out_exception   = 1'b0;
      out_exc_feature = 1'b0;
      if (out_valid) begin
         out_encoded     = head_word;
         out_class       = head_class;
         out_subclass    = head_sub;
         out_exception   = head_illegal | head_feature;
         out_exc_feature = head_feature;
      end
   end

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (do_enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (do_enq && !do_deq) count_d = count_q + CNT_ONE;
         if (!do_enq && do_deq) count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   always_ff @(posedge g_clk) begin
      if (do_enq) begin
         word_q[wr_ptr_q] <= in_encoded;
         mccr_q[wr_ptr_q] <= mccr_masked;
      end
   end

endmodule

// File: tb/tb_scarv_cop_idecode_queue.sv
// tb/tb_scarv_cop_idecode_queue.sv - self-checking bench for scarv_cop_idecode_queue against a queue model
module tb_scarv_cop_idecode_queue;

   localparam int DEPTH = 4;
`ifdef SCARV_COP_IDQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        g_clk, g_resetn, flush, in_valid, out_ready;
   logic [31:0] in_encoded;
   logic [7:0]  mccr;
   logic        in_ready, out_valid, out_exception, out_exc_feature;
   logic [31:0] out_encoded;
   logic [8:0]  out_class;
   logic [15:0] out_subclass;
   logic [2:0]  count;
   logic        m_in_ready, m_out_valid, m_out_exception, m_out_exc_feature;
   logic [31:0] m_out_encoded;
   logic [8:0]  m_out_class;
   logic [15:0] m_out_subclass;
   logic [2:0]  m_count;

   typedef struct packed { logic [31:0] w; logic [7:0] m; } entry_t;
   entry_t q[$];
   int n_tests = 0;
   int n_fail  = 0;

   scarv_cop_idecode_queue #(.DEPTH(DEPTH), .MCCR_MASK(8'hFF)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_encoded(in_encoded), .mccr(mccr),
      .out_valid(out_valid), .out_ready(out_ready), .out_encoded(out_encoded),
      .out_class(out_class), .out_subclass(out_subclass),
      .out_exception(out_exception), .out_exc_feature(out_exc_feature), .count(count)
   );

   scarv_cop_idecode_queue #(.DEPTH(DEPTH), .MCCR_MASK(8'hEF)) dut_m (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(m_in_ready), .in_encoded(in_encoded), .mccr(mccr),
      .out_valid(m_out_valid), .out_ready(out_ready), .out_encoded(m_out_encoded),
      .out_class(m_out_class), .out_subclass(m_out_subclass),
      .out_exception(m_out_exception), .out_exc_feature(m_out_exc_feature), .count(m_count)
   );

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Word layout: [31:28] class, [27:24] subclass, [23:21] pack width, [6:0] opcode 0x0b.
   function automatic logic [26:0] ref_decode(input logic [31:0] w, input logic [7:0] m);
      int ci, si, pw;
      logic [8:0]  c;
      logic [15:0] s;
      logic        ill, f;
      ci  = int'(w[31:28]);
      si  = int'(w[27:24]);
      pw  = int'(w[23:21]);
      c   = (ci < 9) ? 9'(1 << ci) : 9'd0;
      s   = 16'(1 << si);
      ill = (w[6:0] != 7'h0b) || (ci >= 9) || (ci == 0 && pw > 4);
      f   = (ci == 3 && !m[0]) || (ci == 5 && !m[1])
         || (ci == 2 && si >= 4 && si <= 7 && !m[2])
         || (ci == 0 && pw <= 4 && !m[3 + pw]);
      return {c, s, ill | f, f};
   endfunction

   function automatic logic [63:0] model_vec(input logic [7:0] mask);
      logic        byp;
      entry_t      h;
      logic [63:0] r;
      byp = BYP && q.size() == 0 && in_valid && !flush && g_resetn;
      h = '0;
      if (byp) begin
         h.w = in_encoded;
         h.m = mccr;
      end else if (q.size() != 0) begin
         h = q[0];
      end
      r = '0;
      r[63]    = byp || q.size() != 0;
      r[62]    = q.size() != DEPTH;
      r[61:59] = 3'(q.size());
      if (r[63]) r[58:0] = {h.w, ref_decode(h.w, h.m & mask)};
      return r;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [6:0] opc;
      opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'h0b;
      return {4'($urandom_range(0, 9)), 4'($urandom), 3'($urandom_range(0, 5)), 14'($urandom), opc};
   endfunction

   task automatic clk_step();
      logic   byp, enq, deq;
      entry_t ent, dropped;
      byp = BYP && q.size() == 0 && in_valid && !flush;
      ent.w = in_encoded;
      ent.m = mccr;
      if (flush) begin
         q.delete();
      end else begin
         deq = q.size() != 0 && out_ready;
         enq = in_valid && q.size() < DEPTH && !(byp && out_ready);
         if (deq) dropped = q.pop_front();
         if (enq) q.push_back(ent);
      end
      @(posedge g_clk);
      #1;
   endtask

   task automatic test_reset();
      g_resetn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_encoded = 32'h3000000b; mccr = 8'hFF;
      #2;
      g_resetn = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge g_clk); #1;
      @(posedge g_clk); #1;
      n_tests++;
      if ({out_valid, in_ready, count} !== 5'b01000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 01000", {out_valid, in_ready, count});
      end
      n_tests++;
      if ({out_encoded, out_class, out_subclass, out_exception, out_exc_feature} !== 59'd0) begin
         n_fail++;
         $display("FAIL reset_fields: got %h expected 0",
                  {out_encoded, out_class, out_subclass, out_exception, out_exc_feature});
      end
      q.delete();
      in_valid = 1'b0;
      out_ready = 1'b0;
      g_resetn = 1'b1;
      #1;
   endtask

   task automatic test_fill();
      logic [31:0] first;
      first = '0;
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1; out_ready = 1'b0; mccr = 8'hFF;
         in_encoded = rand_word();
         if (i == 0) first = in_encoded;
         #1;
         clk_step();
      end
      in_valid = 1'b1;
      in_encoded = rand_word();
      #1;
      n_tests++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_full: got count=%0d in_ready=%b expected count=4 in_ready=0", count, in_ready);
      end
      n_tests++;
      if (out_encoded !== first) begin
         n_fail++;
         $display("FAIL fill_head: got %h expected %h", out_encoded, first);
      end
      clk_step();
      n_tests++;
      if (count !== 3'd4 || out_encoded !== first) begin
         n_fail++;
         $display("FAIL fill_hold: got count=%0d head=%h expected count=4 head=%h", count, out_encoded, first);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_encoded = rand_word();
         #1;
         exp = model_vec(8'hFF);
         n_tests++;
         if ({out_valid, in_ready, count, out_encoded, out_class, out_subclass,
              out_exception, out_exc_feature} !== exp || count > 3'd4) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d: got %h expected %h", i,
                     {out_valid, in_ready, count, out_encoded, out_class, out_subclass,
                      out_exception, out_exc_feature}, exp);
         end
         clk_step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 8 && q.size() != 0; i++) begin
         #1;
         exp = model_vec(8'hFF);
         n_tests++;
         if ({out_valid, in_ready, count, out_encoded, out_class, out_subclass,
              out_exception, out_exc_feature} !== exp) begin
            n_fail++;
            $display("FAIL drain_cycle%0d: got %h expected %h", i,
                     {out_valid, in_ready, count, out_encoded, out_class, out_subclass,
                      out_exception, out_exc_feature}, exp);
         end
         clk_step();
      end
      n_tests++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: got count=%0d out_valid=%b expected 0 0", count, out_valid);
      end
   endtask

   task automatic test_stored_mccr();
      in_valid = 1'b1; out_ready = 1'b0; mccr = 8'hFE;
      in_encoded = {4'd3, 4'd0, 3'd0, 14'd0, 7'h0b};
      #1;
      clk_step();
      in_valid = 1'b0; mccr = 8'hFF;
      #1;
      n_tests++;
      if ({out_valid, out_exception, out_exc_feature} !== 3'b111) begin
         n_fail++;
         $display("FAIL rngsamp_stored_mccr: got valid/exc/feat=%b expected 111",
                  {out_valid, out_exception, out_exc_feature});
      end
      out_ready = 1'b1;
      clk_step();
      out_ready = 1'b0;
   endtask

   task automatic test_padd_mask();
      in_valid = 1'b1; out_ready = 1'b0; mccr = 8'hEF;
      in_encoded = {4'd0, 4'd0, 3'd1, 14'd0, 7'h0b};
      #1;
      clk_step();
      in_valid = 1'b0;
      #1;
      n_tests++;
      if ({out_exception, out_exc_feature} !== 2'b11) begin
         n_fail++;
         $display("FAIL padd16_mccr: got exc/feat=%b expected 11", {out_exception, out_exc_feature});
      end
      out_ready = 1'b1;
      clk_step();
      in_valid = 1'b1; out_ready = 1'b0; mccr = 8'hFF;
      #1;
      clk_step();
      in_valid = 1'b0;
      #1;
      n_tests++;
      if ({m_out_valid, m_out_exception, m_out_exc_feature} !== 3'b111) begin
         n_fail++;
         $display("FAIL padd16_mask: got valid/exc/feat=%b expected 111",
                  {m_out_valid, m_out_exception, m_out_exc_feature});
      end
      n_tests++;
      if ({out_valid, out_exception, out_exc_feature} !== 3'b100) begin
         n_fail++;
         $display("FAIL padd16_enabled: got valid/exc/feat=%b expected 100",
                  {out_valid, out_exception, out_exc_feature});
      end
      out_ready = 1'b1;
      clk_step();
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      mccr = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; out_ready = 1'b0; in_encoded = rand_word();
         #1;
         clk_step();
      end
      n_tests++;
      if (count !== 3'd3) begin
         n_fail++;
         $display("FAIL flush_pre: got count=%0d expected 3", count);
      end
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_encoded = rand_word();
      #1;
      clk_step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      n_tests++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_post: got count=%0d out_valid=%b in_ready=%b expected 0 0 1",
                  count, out_valid, in_ready);
      end
   endtask

   task automatic test_latency();
      logic [31:0] w;
      w = {4'd4, 4'd2, 3'd0, 14'h1234, 7'h0b};
      in_valid = 1'b1; out_ready = 1'b1; mccr = 8'hFF; in_encoded = w;
      #1;
      n_tests++;
      if (out_valid !== BYP || out_encoded !== (BYP ? w : 32'd0)) begin
         n_fail++;
         $display("FAIL latency_same_cycle: got valid=%b word=%h expected valid=%b", out_valid, out_encoded, BYP);
      end
      clk_step();
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      n_tests++;
      if (count !== (BYP ? 3'd0 : 3'd1) || out_valid !== !BYP) begin
         n_fail++;
         $display("FAIL latency_next_cycle: got count=%0d valid=%b expected count=%0d valid=%b",
                  count, out_valid, BYP ? 0 : 1, !BYP);
      end
      out_ready = 1'b1;
      clk_step();
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; out_ready = 1'b0; in_encoded = rand_word();
         #1;
         clk_step();
      end
      in_valid = 1'b0;
      g_resetn = 1'b0;
      #1;
      n_tests++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: got count=%0d valid=%b ready=%b expected 0 0 1", count, out_valid, in_ready);
      end
      q.delete();
      @(posedge g_clk); #1;
      g_resetn = 1'b1;
      #1;
   endtask

   task automatic test_random();
      logic [63:0] exp, exp_m;
      for (int i = 0; i < 400; i++) begin
         in_valid   = ($urandom_range(0, 9) < 7);
         out_ready  = ($urandom_range(0, 9) < 6);
         flush      = ($urandom_range(0, 31) == 0);
         mccr       = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
         in_encoded = rand_word();
         #1;
         exp   = model_vec(8'hFF);
         exp_m = model_vec(8'hEF);
         n_tests++;
         if ({out_valid, in_ready, count, out_encoded, out_class, out_subclass,
              out_exception, out_exc_feature} !== exp) begin
            n_fail++;
            $display("FAIL random%0d: got %h expected %h", i,
                     {out_valid, in_ready, count, out_encoded, out_class, out_subclass,
                      out_exception, out_exc_feature}, exp);
         end
         n_tests++;
         if ({m_out_valid, m_in_ready, m_count, m_out_encoded, m_out_class, m_out_subclass,
              m_out_exception, m_out_exc_feature} !== exp_m) begin
            n_fail++;
            $display("FAIL random_mask%0d: got %h expected %h", i,
                     {m_out_valid, m_in_ready, m_count, m_out_encoded, m_out_class, m_out_subclass,
                      m_out_exception, m_out_exc_feature}, exp_m);
         end
         clk_step();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_back_to_back();
      test_stored_mccr();
      test_padd_mask();
      test_flush();
      test_latency();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/scarv_cop_idecode_queue.md
SCARV_COP_IDECODE_QUEUE -- requirements
Module: scarv_cop_idecode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered instructions; legal values are 2, 4 and 8.
REQ-002 SHALL have parameter MCCR_MASK, default 8'hFF, meaning features physically present; an absent feature is treated as disabled regardless of mccr.
REQ-003 SHALL have port g_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port g_resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: discard all buffered entries.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_encoded (input, 32): the enqueue handshake and raw instruction word.
REQ-007 SHALL have port mccr, input, 8 bits: runtime feature enables {P2,P4,P8,P16,P32,SG,MP,R} for bits [7:0].
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the dequeue handshake.
REQ-009 SHALL have ports out_encoded (output, 32), out_class (output, 9) and out_subclass (output, 16): the head-entry word, one-hot class and subclass.
REQ-010 SHALL have ports out_exception (output, 1) and out_exc_feature (output, 1): any illegal-instruction condition, and the feature-disabled cause.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-012 SHALL enqueue on a rising edge where in_valid && in_ready && !flush, storing in_encoded together with (mccr & MCCR_MASK) sampled in that cycle.
REQ-013 SHALL drive in_ready = (count != DEPTH); a dequeue in the same cycle SHALL NOT make a full queue ready.
REQ-014 SHALL dequeue on a rising edge where out_valid && out_ready && !flush.
REQ-015 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-016 SHALL wrap the read and write pointers modulo DEPTH; entries SHALL leave in strict FIFO order.
REQ-017 SHALL drive out_valid = (count != 0), except as extended by REQ-027.
REQ-018 SHALL hold all out_* fields stable while out_valid && !out_ready, until flush.
REQ-019 SHALL compute out_class, out_subclass and the base illegal condition combinationally from the head entry's word, via sub-module scarv_cop_idec_core.
REQ-020 SHALL assert out_exc_feature for the head entry when any of the following holds, using the head entry's stored mccr: random class with R=0; MP class with MP=0; scatter/gather subclass with SG=0; packed-arith class whose pack width is 32/16/8/4/2 with the matching P bit 0.
REQ-021 SHALL drive out_exception = base illegal | out_exc_feature; an excepting entry SHALL still dequeue normally.
REQ-022 SHALL, on a flush edge, set count to 0 and set both pointers to 0; flush SHALL win over a simultaneous enqueue and dequeue, neither of which takes effect.
REQ-023 SHALL drive all out_* fields to zero whenever out_valid=0.

Reset
REQ-024 SHALL, while g_resetn=0, asynchronously clear count and both pointers, giving out_valid=0, in_ready=1 and all out_* fields zero.
REQ-025 SHALL NOT require storage contents to be reset.
REQ-026 SHALL discard any partially completed handshake on reset; no entry survives reset.

Configuration
REQ-027 SHALL, with SCARV_COP_IDQ_BYPASS_EN defined, pass in_encoded and the current mccr straight to the outputs when count==0 && in_valid && !flush, so out_valid=1 in the same cycle (0-cycle latency); if out_ready=1 in that cycle the entry SHALL NOT be stored.
REQ-028 SHALL, without SCARV_COP_IDQ_BYPASS_EN, have a minimum enqueue-to-out_valid latency of exactly 1 cycle.

Structure
REQ-029 SHALL place the MCCR bit-index constants, ICLASS/SCLASS index constants and pack-width codes in the shared cop common package or include.
REQ-030 SHALL contain exactly one sub-module, scarv_cop_idec_core, which is purely combinational and decodes word to class, subclass, pack width and base illegal condition; all sequential logic stays in this block.

Verification
REQ-031 SHALL cover reset then 4 back-to-back enqueues with out_ready=0 and DEPTH=4: count=4, in_ready=0, and out_encoded equals the first word.
REQ-032 SHALL cover a full queue with out_ready=1 for 6 cycles and in_valid=1 carrying new words: output order matches input order across pointer wrap, and count never exceeds 4.
REQ-033 SHALL cover an rngsamp encoding enqueued with mccr=8'hFE, after which mccr changes to 8'hFF before dequeue: out_exception=1 and out_exc_feature=1, because the stored mccr is used.
REQ-034 SHALL cover a padd encoding with pack width 16 and mccr=8'hEF, and also with MCCR_MASK=8'hEF and mccr=8'hFF: out_exc_feature=1 in both cases.
REQ-035 SHALL cover flush asserted with count=3, in_valid=1 and out_ready=1: next cycle count=0 and out_valid=0, with nothing enqueued or dequeued.
REQ-036 SHALL cover, with SCARV_COP_IDQ_BYPASS_EN, an empty queue with in_valid=1 and out_ready=1: out_valid=1 in the same cycle and count remains 0; without the macro, out_valid rises one cycle later.
